imem_program_loader: RTL and testbench

- Encoder counterpart to the opcode control decoder.
- Accepts symbolic instruction descriptors (operation select plus register and immediate fields) over a valid/ready handshake.
- Packs each descriptor into a 32-bit MIPS word for the six supported instructions (add, addi, beq, j, lw, sw) and writes it sequentially into instruction memory.
- On command, appends a jump-to-self terminator. It sits between the testbench or boot source and the instruction memory write port.

---
 rtl/imem_program_loader.sv | 185 ++++++++++++++++++
 tb/tb_imem_program_loader.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_program_loader.sv
// Packs symbolic instruction descriptors into MIPS words and streams them into
// instruction memory, closing each program with a jump-to-self terminator.
module imem_program_loader #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op_sel,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              done,
  output logic [ADDR_W:0]   prog_len,
  output logic              err_illegal
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_TERM = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t              state_r, state_nxt_s;
  logic [ADDR_W-1:0]   wr_ptr_r, wr_ptr_nxt_s;
  logic                we_r, we_nxt_s;
  logic [ADDR_W-1:0]   addr_r, addr_nxt_s;
  logic [31:0]         wdata_r, wdata_nxt_s;
  logic                done_r;
  logic [ADDR_W:0]     len_r, len_nxt_s;
  logic                err_r, err_nxt_s;
  logic                in_ready_s;
  logic                accept_s;
  logic [25:0]         term_tgt_s;

  function automatic logic op_legal(input logic [2:0] op);
    return (op <= 3'd5);
  endfunction

  function automatic logic [31:0] encode_instr(
    input logic [2:0]  op,
    input logic [4:0]  f_rs,
    input logic [4:0]  f_rt,
    input logic [4:0]  f_rd,
    input logic [15:0] f_imm,
    input logic [25:0] f_tgt
  );
    logic [31:0] word;
    case (op)
      3'd0:    word = {6'b000000, f_rs, f_rt, f_rd, 5'b00000, 6'b100000};
      3'd1:    word = {6'b001000, f_rs, f_rt, f_imm};
      3'd2:    word = {6'b000100, f_rs, f_rt, f_imm};
      3'd3:    word = {6'b000010, f_tgt};
      3'd4:    word = {6'b100011, f_rs, f_rt, f_imm};
      3'd5:    word = {6'b101011, f_rs, f_rt, f_imm};
      default: word = 32'h0000_0000;
    endcase
    return word;
  endfunction

  assign accept_s   = in_valid & in_ready_s;
  assign term_tgt_s = 26'(wr_ptr_r);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; start outranks finish everywhere.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: state_nxt_s = start ? ST_LOAD : ST_IDLE;
      ST_LOAD: begin
        if (start) begin
          state_nxt_s = ST_LOAD;
        end else if (finish) begin
          state_nxt_s = ST_TERM;
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      ST_TERM: state_nxt_s = start ? ST_LOAD : ST_DONE;
      ST_DONE: state_nxt_s = start ? ST_LOAD : ST_DONE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output/datapath next values; the top slot stays free for the terminator.
  always_comb begin
    in_ready_s   = 1'b0;
    wr_ptr_nxt_s = wr_ptr_r;
    we_nxt_s     = 1'b0;
    addr_nxt_s   = addr_r;
    wdata_nxt_s  = wdata_r;
    len_nxt_s    = len_r;
    err_nxt_s    = err_r;
    case (state_r)
      ST_LOAD: begin
        in_ready_s = (wr_ptr_r != {ADDR_W{1'b1}});
        if (start) begin
          wr_ptr_nxt_s = {ADDR_W{1'b0}};
          err_nxt_s    = 1'b0;
        end else if (accept_s) begin
          if (op_legal(op_sel)) begin
            we_nxt_s     = 1'b1;
            addr_nxt_s   = wr_ptr_r;
            wdata_nxt_s  = encode_instr(op_sel, rs, rt, rd, imm, target);
            wr_ptr_nxt_s = wr_ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
          end else begin
            err_nxt_s = 1'b1;
          end
        end else begin
          wr_ptr_nxt_s = wr_ptr_r;
        end
      end
      ST_TERM: begin
        we_nxt_s    = 1'b1;
        addr_nxt_s  = wr_ptr_r;
        wdata_nxt_s = {6'b000010, term_tgt_s};
        len_nxt_s   = {1'b0, wr_ptr_r} + {{ADDR_W{1'b0}}, 1'b1};
        if (start) begin
          wr_ptr_nxt_s = {ADDR_W{1'b0}};
          err_nxt_s    = 1'b0;
        end else begin
          wr_ptr_nxt_s = wr_ptr_r;
        end
      end
      ST_IDLE, ST_DONE: begin
        if (start) begin
          wr_ptr_nxt_s = {ADDR_W{1'b0}};
          err_nxt_s    = 1'b0;
        end else begin
          wr_ptr_nxt_s = wr_ptr_r;
        end
      end
      default: begin
        wr_ptr_nxt_s = {ADDR_W{1'b0}};
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {ADDR_W{1'b0}};
      we_r     <= 1'b0;
      addr_r   <= {ADDR_W{1'b0}};
      wdata_r  <= 32'h0000_0000;
      done_r   <= 1'b0;
      len_r    <= {(ADDR_W+1){1'b0}};
      err_r    <= 1'b0;
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      we_r     <= we_nxt_s;
      addr_r   <= addr_nxt_s;
      wdata_r  <= wdata_nxt_s;
      done_r   <= (state_nxt_s == ST_DONE);
      len_r    <= len_nxt_s;
      err_r    <= err_nxt_s;
    end
  end

  assign in_ready    = in_ready_s;
  assign imem_we     = we_r;
  assign imem_addr   = addr_r;
  assign imem_wdata  = wdata_r;
  assign done        = done_r;
  assign prog_len    = len_r;
  assign err_illegal = err_r;

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench for imem_program_loader: a default-depth instance (a) and a
// four-word instance (b) share stimulus; each scenario checks its own results.
module tb_imem_program_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        finish;
  logic        in_valid;
  logic [2:0]  op_sel;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [25:0] target;

  logic        a_in_ready, a_we, a_done, a_err;
  logic [5:0]  a_addr;
  logic [31:0] a_wdata;
  logic [6:0]  a_len;

  logic        b_in_ready, b_we, b_done, b_err;
  logic [1:0]  b_addr;
  logic [31:0] b_wdata;
  logic [2:0]  b_len;

  int n_vec;
  int n_err;

  imem_program_loader #(.ADDR_W(6)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(a_in_ready), .op_sel(op_sel),
    .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
    .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wdata),
    .done(a_done), .prog_len(a_len), .err_illegal(a_err)
  );

  imem_program_loader #(.ADDR_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(b_in_ready), .op_sel(op_sel),
    .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
    .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata),
    .done(b_done), .prog_len(b_len), .err_illegal(b_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start    = 1'b0;
    finish   = 1'b0;
    in_valid = 1'b0;
    op_sel   = 3'd0;
    rs       = 5'd0;
    rt       = 5'd0;
    rd       = 5'd0;
    imm      = 16'h0000;
    target   = 26'h0;
  endtask

  task automatic desc(input logic [2:0] o, input logic [4:0] s, input logic [4:0] t,
                      input logic [4:0] d, input logic [15:0] i, input logic [25:0] g);
    in_valid = 1'b1;
    op_sel   = o;
    rs       = s;
    rt       = t;
    rd       = d;
    imm      = i;
    target   = g;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #3;
    n_vec++;
    if ({a_in_ready, a_we, a_addr, a_wdata, a_done, a_len, a_err} !== 48'h0) begin
      $display("FAIL reset_state: got we=%b addr=%0d wdata=%h done=%b len=%0d err=%b rdy=%b, want all 0",
               a_we, a_addr, a_wdata, a_done, a_len, a_err, a_in_ready);
      n_err++;
    end
    rst_n = 1'b1;
    step();
    finish = 1'b1;
    step();
    finish = 1'b0;
    step();
    n_vec++;
    if ({a_done, a_we, a_in_ready} !== 3'b000) begin
      $display("FAIL idle_finish_ignored: got done=%b we=%b rdy=%b, want 0 0 0", a_done, a_we, a_in_ready);
      n_err++;
    end
  endtask

  task automatic test_single_add();
    do_reset();
    do_start();
    n_vec++;
    if (a_in_ready !== 1'b1) begin
      $display("FAIL load_ready: got %b, want 1", a_in_ready);
      n_err++;
    end
    desc(3'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    step();
    in_valid = 1'b0;
    n_vec++;
    if ({a_we, a_addr, a_wdata} !== {1'b1, 6'd0, 32'h00221820}) begin
      $display("FAIL add_write: got we=%b addr=%0d wdata=%h, want 1 0 00221820", a_we, a_addr, a_wdata);
      n_err++;
    end
    step();
    n_vec++;
    if ({a_we, a_addr, a_wdata} !== {1'b0, 6'd0, 32'h00221820}) begin
      $display("FAIL add_hold: got we=%b addr=%0d wdata=%h, want 0 0 00221820", a_we, a_addr, a_wdata);
      n_err++;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    do_start();
    desc(3'd1, 5'd0, 5'd1, 5'd0, 16'h0005, 26'h0);
    step();
    n_vec++;
    if ({a_we, a_addr, a_wdata} !== {1'b1, 6'd0, 32'h20010005}) begin
      $display("FAIL b2b_addi: got we=%b addr=%0d wdata=%h, want 1 0 20010005", a_we, a_addr, a_wdata);
      n_err++;
    end
    desc(3'd4, 5'd2, 5'd4, 5'd0, 16'h0008, 26'h0);
    step();
    n_vec++;
    if ({a_we, a_addr, a_wdata} !== {1'b1, 6'd1, 32'h8C440008}) begin
      $display("FAIL b2b_lw: got we=%b addr=%0d wdata=%h, want 1 1 8c440008", a_we, a_addr, a_wdata);
      n_err++;
    end
    desc(3'd2, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0);
    step();
    n_vec++;
    if ({a_we, a_addr, a_wdata} !== {1'b1, 6'd2, 32'h1022FFFF}) begin
      $display("FAIL b2b_beq: got we=%b addr=%0d wdata=%h, want 1 2 1022ffff", a_we, a_addr, a_wdata);
      n_err++;
    end
    in_valid = 1'b0;
    finish   = 1'b1;
    step();
    finish = 1'b0;
    n_vec++;
    if ({a_we, a_in_ready, a_done} !== 3'b000) begin
      $display("FAIL b2b_term_cycle: got we=%b rdy=%b done=%b, want 0 0 0", a_we, a_in_ready, a_done);
      n_err++;
    end
    step();
    n_vec++;
    if ({a_we, a_addr, a_wdata, a_done, a_len} !== {1'b1, 6'd3, 32'h08000003, 1'b1, 7'd4}) begin
      $display("FAIL b2b_terminator: got we=%b addr=%0d wdata=%h done=%b len=%0d, want 1 3 08000003 1 4",
               a_we, a_addr, a_wdata, a_done, a_len);
      n_err++;
    end
    finish = 1'b1;
    step();
    finish = 1'b0;
    n_vec++;
    if ({a_we, a_done, a_len} !== {1'b0, 1'b1, 7'd4}) begin
      $display("FAIL done_hold: got we=%b done=%b len=%0d, want 0 1 4", a_we, a_done, a_len);
      n_err++;
    end
    do_start();
    n_vec++;
    if ({a_done, a_in_ready} !== 2'b01) begin
      $display("FAIL done_restart: got done=%b rdy=%b, want 0 1", a_done, a_in_ready);
      n_err++;
    end
  endtask

  task automatic test_full();
    do_reset();
    do_start();
    desc(3'd5, 5'd0, 5'd5, 5'd0, 16'h0004, 26'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if ({b_we, b_addr, b_wdata} !== {1'b1, 2'(i), 32'hAC050004}) begin
        $display("FAIL full_sw%0d: got we=%b addr=%0d wdata=%h, want 1 %0d ac050004", i, b_we, b_addr, b_wdata, i);
        n_err++;
      end
    end
    n_vec++;
    if (b_in_ready !== 1'b0) begin
      $display("FAIL full_stall_ready: got %b, want 0", b_in_ready);
      n_err++;
    end
    step();
    n_vec++;
    if (b_we !== 1'b0) begin
      $display("FAIL full_no_write: got we=%b, want 0", b_we);
      n_err++;
    end
    finish = 1'b1;
    step();
    finish   = 1'b0;
    in_valid = 1'b0;
    step();
    n_vec++;
    if ({b_we, b_addr, b_wdata, b_done, b_len} !== {1'b1, 2'd3, 32'h08000003, 1'b1, 3'd4}) begin
      $display("FAIL full_terminator: got we=%b addr=%0d wdata=%h done=%b len=%0d, want 1 3 08000003 1 4",
               b_we, b_addr, b_wdata, b_done, b_len);
      n_err++;
    end
  endtask

  task automatic test_illegal();
    do_reset();
    do_start();
    desc(3'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    step();
    n_vec++;
    if ({a_we, a_addr, a_wdata} !== {1'b1, 6'd0, 32'h00221820}) begin
      $display("FAIL ill_add0: got we=%b addr=%0d wdata=%h, want 1 0 00221820", a_we, a_addr, a_wdata);
      n_err++;
    end
    desc(3'd7, 5'd9, 5'd9, 5'd9, 16'h1234, 26'h0);
    step();
    n_vec++;
    if ({a_we, a_err} !== 2'b01) begin
      $display("FAIL ill_flag: got we=%b err=%b, want 0 1", a_we, a_err);
      n_err++;
    end
    desc(3'd0, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0);
    step();
    in_valid = 1'b0;
    n_vec++;
    if ({a_we, a_addr, a_wdata, a_err} !== {1'b1, 6'd1, 32'h00853020, 1'b1}) begin
      $display("FAIL ill_add1: got we=%b addr=%0d wdata=%h err=%b, want 1 1 00853020 1",
               a_we, a_addr, a_wdata, a_err);
      n_err++;
    end
    do_start();
    n_vec++;
    if (a_err !== 1'b0) begin
      $display("FAIL ill_clear: got err=%b, want 0", a_err);
      n_err++;
    end
  endtask

  task automatic test_same_cycle_finish();
    do_reset();
    do_start();
    desc(3'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    step();
    desc(3'd3, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10);
    finish = 1'b1;
    step();
    in_valid = 1'b0;
    finish   = 1'b0;
    n_vec++;
    if ({a_we, a_addr, a_wdata} !== {1'b1, 6'd1, 32'h08000010}) begin
      $display("FAIL same_j: got we=%b addr=%0d wdata=%h, want 1 1 08000010", a_we, a_addr, a_wdata);
      n_err++;
    end
    step();
    n_vec++;
    if ({a_we, a_addr, a_wdata, a_done, a_len} !== {1'b1, 6'd2, 32'h08000002, 1'b1, 7'd3}) begin
      $display("FAIL same_term: got we=%b addr=%0d wdata=%h done=%b len=%0d, want 1 2 08000002 1 3",
               a_we, a_addr, a_wdata, a_done, a_len);
      n_err++;
    end
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    do_start();
    desc(3'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    step();
    step();
    step();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({a_in_ready, a_we, a_addr, a_wdata, a_done, a_len, a_err} !== 48'h0) begin
      $display("FAIL midreset_state: got we=%b addr=%0d wdata=%h done=%b len=%0d err=%b rdy=%b, want all 0",
               a_we, a_addr, a_wdata, a_done, a_len, a_err, a_in_ready);
      n_err++;
    end
    #2;
    rst_n = 1'b1;
    step();
    n_vec++;
    if (a_we !== 1'b0) begin
      $display("FAIL midreset_no_write: got we=%b, want 0", a_we);
      n_err++;
    end
    do_start();
    desc(3'd1, 5'd0, 5'd1, 5'd0, 16'h0005, 26'h0);
    step();
    in_valid = 1'b0;
    n_vec++;
    if ({a_we, a_addr, a_wdata} !== {1'b1, 6'd0, 32'h20010005}) begin
      $display("FAIL midreset_first: got we=%b addr=%0d wdata=%h, want 1 0 20010005", a_we, a_addr, a_wdata);
      n_err++;
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_single_add();
    test_back_to_back();
    test_full();
    test_illegal();
    test_same_cycle_finish();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
